// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/sub with optional signed saturation. Each stage resolves one BLOCK-bit slice
// and hands its carry on; a final output register applies saturation and forms the flags.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NSTG = WIDTH / BLOCK;
  localparam int unsigned LAST = NSTG - 1;

  logic                        advance;
  logic [NSTG-1:0]             vld_q, vld_d;
  logic [NSTG-1:0][1:0]        op_q, op_d;
  logic [NSTG-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d, s_in;
  logic [NSTG-1:0]             c_q, c_d, c_in;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             msb_cin, sat;
  logic             unused_last;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Stage k consumes what stage k-1 registered; stage 0 consumes the port (B pre-inverted for sub).
  always_comb begin
    vld_d   = '0;
    op_d    = '0;
    a_d     = '0;
    b_d     = '0;
    s_in    = '0;
    c_in    = '0;
    vld_d[0] = in_valid;
    op_d[0]  = op;
    a_d[0]   = data_A;
    b_d[0]   = op[0] ? ~data_B : data_B;
    c_in[0]  = op[0];
    for (int unsigned k = 1; k < NSTG; k++) begin
      vld_d[k] = vld_q[k-1];
      op_d[k]  = op_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      s_in[k]  = s_q[k-1];
      c_in[k]  = c_q[k-1];
    end
  end

  always_comb begin
    logic [BLOCK-1:0] a_sl;
    logic [BLOCK-1:0] b_sl;
    logic [BLOCK:0]   gen_sum;
    logic             prop;
    a_sl    = '0;
    b_sl    = '0;
    gen_sum = '0;
    prop    = 1'b0;
    s_d     = '0;
    c_d     = '0;
    for (int unsigned k = 0; k < NSTG; k++) begin
      a_sl    = a_d[k][k*BLOCK +: BLOCK];
      b_sl    = b_d[k][k*BLOCK +: BLOCK];
      gen_sum = {1'b0, a_sl} + {1'b0, b_sl};
      prop    = &(a_sl ^ b_sl);
      s_d[k]  = s_in[k];
      s_d[k][k*BLOCK +: BLOCK] = gen_sum[BLOCK-1:0] + BLOCK'(c_in[k]);
      c_d[k]  = gen_sum[BLOCK] | (prop & c_in[k]);
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
  always_comb begin
    msb_cin     = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_q[LAST][WIDTH-1];
    ovf_d       = msb_cin ^ c_q[LAST];
    carry_d     = c_q[LAST];
    sat         = op_q[LAST][1] & ovf_d;
    out_d       = s_q[LAST];
    if (sat) begin
      out_d = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    zero_d      = (out_d == '0);
    out_valid_d = vld_q[LAST];
  end

  assign unused_last = ^{a_q[LAST], b_q[LAST], op_q[LAST][0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      vld_q       <= vld_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed corner beats, stall/stream, async reset flush and a
// long random run, all scored against an arithmetic reference model through an in-order queue.
module tb_pipelined_cla_addsub;

  localparam int unsigned W    = 32;
  localparam int unsigned NSTG = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [W-1:0]  data_A, data_B;
  logic [1:0]    op;
  logic          out_valid, out_ready;
  logic [W-1:0]  out;
  logic          carry, overflow, zero;

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_A    (data_A),
    .data_B    (data_B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned sum for result/carry, signed integer range test for overflow.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bb;
    logic [W:0]   full;
    longint       s;
    longint       lim;
    exp_t         e;
    lim  = 64'sd2147483648;
    bb   = o[0] ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, o[0]};
    s    = longint'($signed(a)) + longint'($signed(bb)) + longint'({63'd0, o[0]});
    e.o  = (s >= lim) || (s < -lim);
    e.c  = full[W];
    e.res = full[W-1:0];
    if (o[1] && e.o) e.res = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.z  = (e.res == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: push on accept, pop and compare on result handshake, check hold while stalled.
  logic         stall_prev = 1'b0;
  logic [35:0]  held = '0;

  always @(negedge clock) begin
    if (!reset) begin
      q.delete();
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", 64'({out_valid, out, carry, overflow, zero}), 64'(held));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got out=%0h with no beat outstanding, required none",
                   out);
        end else begin
          n_out++;
          chk("result", 64'({out, carry, overflow, zero}), 64'(q.pop_front()));
        end
      end
      if (in_valid && in_ready) q.push_back(model(op, data_A, data_B));
      stall_prev <= out_valid && !out_ready;
      held       <= {out_valid, out, carry, overflow, zero};
    end
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive_cycle(input logic v, input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic ordy,
                             output logic took, output logic rdy);
    in_valid  = v;
    op        = o;
    data_A    = a;
    data_B    = b;
    out_ready = ordy;
    #1;
    rdy  = in_ready;
    took = v && in_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic single(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ec, input logic eo, input logic ez);
    exp_t lit;
    lit = {er, ec, eo, ez};
    chk("model_pin", 64'(model(o, a, b)), 64'(lit));
    in_valid  = 1'b1;
    op        = o;
    data_A    = a;
    data_B    = b;
    out_ready = 1'b1;
    #1;
    chk("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    op       = 2'($urandom_range(0, 3));
    data_A   = $urandom;
    data_B   = $urandom;
    for (int i = 1; i <= NSTG; i++) begin
      chk("latency_early", 64'(out_valid), 64'd0);
      @(posedge clock);
      #1;
    end
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("directed_result", 64'({out, carry, overflow, zero}), 64'(lit));
    @(posedge clock);
    #1;
    chk("directed_drained", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1);
  end

  initial begin
    logic took, rdy, ordy;
    int   idx, cyc, n0, accepted;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_A    = '0;
    data_B    = '0;
    op        = 2'b00;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({out, carry, overflow, zero}), 64'd0);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    @(posedge clock);
    #1;

    single(2'b00, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    single(2'b01, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    single(2'b01, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    single(2'b10, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    single(2'b11, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    single(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    single(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Stream of 8 beats with a 3-cycle downstream stall once the first result is out.
    n0  = n_out;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      ordy = !(cyc >= 5 && cyc <= 7);
      drive_cycle(1'b1, 2'($urandom_range(0, 3)), pick(), pick(), ordy, took, rdy);
      if (cyc >= 5 && cyc <= 7) chk("stall_in_ready", 64'(rdy), 64'd0);
      if (took) idx++;
      cyc++;
    end
    repeat (12) drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, took, rdy);
    chk("stream_count", 64'(n_out - n0), 64'd8);
    chk("stream_empty", 64'(q.size()), 64'd0);

    // Three beats in flight, the oldest stalled at the output, then reset between edges.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'($urandom_range(0, 3)), pick(), pick(),
                                            1'b1, took, rdy);
    repeat (3) drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, took, rdy);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_outputs", 64'({out, carry, overflow, zero}), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #3 reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, took, rdy);
      chk("no_stale_after_reset", 64'(out_valid), 64'd0);
    end
    single(2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Random traffic with random op, bubbles and backpressure.
    accepted = 0;
    cyc      = 0;
    while (accepted < 10000 && cyc < 60000) begin
      drive_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick(), pick(),
                  $urandom_range(0, 3) != 0, took, rdy);
      if (took) accepted++;
      cyc++;
    end
    repeat (12) drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, took, rdy);
    chk("random_accepted", 64'(accepted), 64'd10000);
    chk("random_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
